// File: rtl/float_fixed_overflow_pipe.sv
// Two-stage overflow analyser for float-to-fixed conversion: reports how many extra
// integer bits a sample needs at its radix point, flags Inf/NaN, and keeps sticky/count status.
module float_fixed_overflow_pipe #(
    parameter int FLOATSIZE      = 32,
    parameter int EXPONENTBITS   = 8,
    parameter int MANTISSABITS   = 23,
    parameter int FIXEDSIZE      = 32,
    parameter int RADIXPOINTSIZE = 6,
    parameter int OVERFLOWBITS   = 6,
    parameter int COUNTBITS      = 16,
    parameter int BIAS           = 2**(EXPONENTBITS-1)-1
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [FLOATSIZE-1:0]      InFloat,
    input  logic [RADIXPOINTSIZE-1:0] InRadixPoint,
    input  logic                      InValid,
    output logic                      OutReady,
    output logic [OVERFLOWBITS-1:0]   OutOverflow,
    output logic                      OutOvfFlag,
    output logic                      OutSpecial,
    output logic                      OutValid,
    input  logic                      InReady,
    input  logic                      InClear,
    output logic                      OutSticky,
    output logic [COUNTBITS-1:0]      OutOvfCount
);

    localparam int FIXW  = $clog2(FIXEDSIZE + 1);
    localparam int AW    = ((RADIXPOINTSIZE > FIXW) ? RADIXPOINTSIZE : FIXW) + 2;
    localparam int MAXW1 = (EXPONENTBITS > AW) ? EXPONENTBITS : AW;
    localparam int FW    = ((MAXW1 > OVERFLOWBITS) ? MAXW1 : OVERFLOWBITS) + 3;
    localparam logic signed [FW-1:0] OVF_LIM = FW'(2**OVERFLOWBITS);

    // Handshake: a sample moves on a cycle where its valid and the receiver's ready are both
    // high. A full stage holds its data until the next stage advances, so valid never drops early.
    logic s2_adv, s1_adv, out_xfer;

    logic                        s1_valid_q, s1_valid_d;
    logic                        s1_sign_q, s1_sign_d;
    logic [EXPONENTBITS-1:0]     s1_exp_q, s1_exp_d;
    logic                        s1_normal_q, s1_normal_d;
    logic                        s1_special_q, s1_special_d;
    logic signed [AW-1:0]        s1_avail_q, s1_avail_d;

    logic                        s2_valid_q, s2_valid_d;
    logic [OVERFLOWBITS-1:0]     s2_overflow_q, s2_overflow_d;
    logic                        s2_flag_q, s2_flag_d;
    logic                        s2_special_q, s2_special_d;

    logic                        sticky_q, sticky_d;
    logic [COUNTBITS-1:0]        count_q, count_d;

    logic [EXPONENTBITS-1:0]     exp_in;
    logic signed [FW-1:0]        e_unb, avail_ext, full;
    logic [OVERFLOWBITS-1:0]     ovf_calc;

    // Sign and mantissa do not affect the integer-bit requirement.
    logic unused_bits;
    assign unused_bits = ^{s1_sign_q, InFloat[MANTISSABITS-1:0]};

    assign s2_adv   = !s2_valid_q | InReady;
    assign s1_adv   = !s1_valid_q | s2_adv;
    assign out_xfer = s2_valid_q & InReady;
    assign exp_in   = InFloat[FLOATSIZE-2 -: EXPONENTBITS];

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_sign_d    = s1_sign_q;
        s1_exp_d     = s1_exp_q;
        s1_normal_d  = s1_normal_q;
        s1_special_d = s1_special_q;
        s1_avail_d   = s1_avail_q;
        if (s1_adv) begin
            s1_valid_d   = InValid;
            s1_sign_d    = InFloat[FLOATSIZE-1];
            s1_exp_d     = exp_in;
            s1_normal_d  = (exp_in != '0) && (exp_in != '1);
            s1_special_d = (exp_in == '1);
            s1_avail_d   = AW'(FIXEDSIZE - 1) - AW'(InRadixPoint);
        end
    end

    always_comb begin
        e_unb     = $signed(FW'(s1_exp_q)) - FW'(BIAS);
        avail_ext = FW'(s1_avail_q);
        full      = e_unb - avail_ext + FW'(1);
        ovf_calc  = '0;
        if (s1_special_q) begin
            ovf_calc = '1;
        end else if (s1_normal_q && (e_unb >= avail_ext)) begin
            ovf_calc = (full >= OVF_LIM) ? '1 : full[OVERFLOWBITS-1:0];
        end
    end

    always_comb begin
        s2_valid_d    = s2_valid_q;
        s2_overflow_d = s2_overflow_q;
        s2_flag_d     = s2_flag_q;
        s2_special_d  = s2_special_q;
        if (s2_adv) begin
            s2_valid_d    = s1_valid_q;
            s2_overflow_d = ovf_calc;
            s2_flag_d     = (ovf_calc != '0);
            s2_special_d  = s1_special_q;
        end
    end

    // Status only moves on delivery, so a stalled result is counted exactly once.
    always_comb begin
        sticky_d = sticky_q;
        count_d  = count_q;
        if (InClear) begin
            sticky_d = 1'b0;
            count_d  = '0;
        end else if (out_xfer && s2_flag_q) begin
            sticky_d = 1'b1;
            if (count_q != '1) begin
                count_d = count_q + COUNTBITS'(1);
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            s1_valid_q    <= 1'b0;
            s1_sign_q     <= 1'b0;
            s1_exp_q      <= '0;
            s1_normal_q   <= 1'b0;
            s1_special_q  <= 1'b0;
            s1_avail_q    <= '0;
            s2_valid_q    <= 1'b0;
            s2_overflow_q <= '0;
            s2_flag_q     <= 1'b0;
            s2_special_q  <= 1'b0;
            sticky_q      <= 1'b0;
            count_q       <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_sign_q     <= s1_sign_d;
            s1_exp_q      <= s1_exp_d;
            s1_normal_q   <= s1_normal_d;
            s1_special_q  <= s1_special_d;
            s1_avail_q    <= s1_avail_d;
            s2_valid_q    <= s2_valid_d;
            s2_overflow_q <= s2_overflow_d;
            s2_flag_q     <= s2_flag_d;
            s2_special_q  <= s2_special_d;
            sticky_q      <= sticky_d;
            count_q       <= count_d;
        end
    end

    assign OutReady    = s1_adv;
    assign OutValid    = s2_valid_q;
    assign OutOverflow = s2_overflow_q;
    assign OutOvfFlag  = s2_flag_q;
    assign OutSpecial  = s2_special_q;
    assign OutSticky   = sticky_q;
    assign OutOvfCount = count_q;

endmodule

// File: tb/tb_float_fixed_overflow_pipe.sv
// Bench for float_fixed_overflow_pipe at FIXEDSIZE=16, COUNTBITS=4: directed boundary
// cases plus randomized traffic scored against a magnitude-based reference model.
module tb_float_fixed_overflow_pipe;

    logic        Clk;
    logic        Rst;
    logic [31:0] InFloat;
    logic [5:0]  InRadixPoint;
    logic        InValid;
    logic        OutReady;
    logic [5:0]  OutOverflow;
    logic        OutOvfFlag;
    logic        OutSpecial;
    logic        OutValid;
    logic        InReady;
    logic        InClear;
    logic        OutSticky;
    logic [3:0]  OutOvfCount;

    float_fixed_overflow_pipe #(
        .FLOATSIZE(32), .EXPONENTBITS(8), .MANTISSABITS(23), .FIXEDSIZE(16),
        .RADIXPOINTSIZE(6), .OVERFLOWBITS(6), .COUNTBITS(4)
    ) dut (
        .Clk(Clk), .Rst(Rst), .InFloat(InFloat), .InRadixPoint(InRadixPoint),
        .InValid(InValid), .OutReady(OutReady), .OutOverflow(OutOverflow),
        .OutOvfFlag(OutOvfFlag), .OutSpecial(OutSpecial), .OutValid(OutValid),
        .InReady(InReady), .InClear(InClear), .OutSticky(OutSticky),
        .OutOvfCount(OutOvfCount)
    );

    // ---------------- clock / reset ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_xfer = 0;
    logic stall_seen;

    // ---------------- reference model ----------------
    // {special, overflow}. A normal value with unbiased exponent k lies in [2^k, 2^(k+1)),
    // so it needs k+1 integer bits plus a sign bit; the format offers 16-r integer bits.
    function automatic logic [6:0] model(input logic [31:0] f, input int r);
        int e;
        int extra;
        e = int'(f[30:23]);
        if (e == 255) return {1'b1, 6'd63};
        if (e == 0) return 7'd0;
        extra = ((e - 127) + 2) - (16 - r);
        if (extra <= 0) return 7'd0;
        if (extra > 63) extra = 63;
        return {1'b0, 6'(extra)};
    endfunction

    function automatic logic [31:0] rand_float();
        logic [7:0] e;
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) e = 8'h00;
        else if (sel == 1) e = 8'hFF;
        else e = 8'($urandom_range(110, 200));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    // ---------------- scoreboard ----------------
    logic [6:0] exp_q[$];
    int         m_count = 0;
    logic       m_sticky = 1'b0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = '0;

    always @(negedge Clk) begin
        logic [6:0] x;
        logic       exp_flag;
        if (Rst) begin
            exp_q.delete();
            m_count   = 0;
            m_sticky  = 1'b0;
            prev_hold = 1'b0;
        end else begin
            n_cmp += 2;
            if (OutOvfCount !== 4'(m_count)) begin
                n_fail++;
                $display("FAIL ovf_count: got %0d expected %0d", OutOvfCount, m_count);
            end
            if (OutSticky !== m_sticky) begin
                n_fail++;
                $display("FAIL sticky: got %0b expected %0b", OutSticky, m_sticky);
            end
            if (prev_hold) begin
                n_cmp++;
                if (OutValid !== 1'b1 || {OutSpecial, OutOvfFlag, OutOverflow} !== prev_data) begin
                    n_fail++;
                    $display("FAIL stall_hold: got v=%0b d=%h expected v=1 d=%h",
                             OutValid, {OutSpecial, OutOvfFlag, OutOverflow}, prev_data);
                end
            end
            exp_flag = 1'b0;
            if (OutValid && InReady) begin
                n_xfer++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_out: got ovf=%0d expected no output", OutOverflow);
                end else begin
                    x = exp_q.pop_front();
                    exp_flag = (x[5:0] != 6'd0);
                    if (OutOverflow !== x[5:0] || OutSpecial !== x[6] || OutOvfFlag !== exp_flag) begin
                        n_fail++;
                        $display("FAIL result: got ovf=%0d spec=%0b flag=%0b expected ovf=%0d spec=%0b flag=%0b",
                                 OutOverflow, OutSpecial, OutOvfFlag, x[5:0], x[6], exp_flag);
                    end
                end
            end
            if (InClear) begin
                m_count  = 0;
                m_sticky = 1'b0;
            end else if (exp_flag) begin
                m_sticky = 1'b1;
                if (m_count < 15) m_count++;
            end
            prev_hold = OutValid && !InReady;
            prev_data = {OutSpecial, OutOvfFlag, OutOverflow};
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 right after the transfer edge.
    task automatic send(input logic [31:0] f, input logic [5:0] r);
        logic done;
        done = 1'b0;
        InFloat = f;
        InRadixPoint = r;
        InValid = 1'b1;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge Clk);
            if (OutReady) begin
                exp_q.push_back(model(f, int'(r)));
                done = 1'b1;
            end else begin
                stall_seen = 1'b1;
            end
            @(posedge Clk);
            #1;
        end
        InValid = 1'b0;
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: got OutReady=0 expected 1 within 100 cycles");
        end
    endtask

    task automatic wait_out(output logic [5:0] ovf, output logic spec, output logic flag);
        logic seen;
        seen = 1'b0;
        ovf = '0;
        spec = 1'b0;
        flag = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge Clk);
            if (OutValid) begin
                seen = 1'b1;
                ovf = OutOverflow;
                spec = OutSpecial;
                flag = OutOvfFlag;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_out_timeout: got OutValid=0 expected 1 within 10 cycles");
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic drain();
        logic empty;
        empty = 1'b0;
        for (int t = 0; t < 300 && !empty; t++) begin
            @(posedge Clk);
            #1;
            empty = (exp_q.size() == 0);
        end
        if (!empty) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic clear_status();
        InClear = 1'b1;
        @(posedge Clk);
        #1;
        InClear = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1;
        n_cmp += 7;
        if (OutValid !== 1'b0)    begin n_fail++; $display("FAIL rst_valid: got %0b expected 0", OutValid); end
        if (OutReady !== 1'b1)    begin n_fail++; $display("FAIL rst_ready: got %0b expected 1", OutReady); end
        if (OutOverflow !== 6'd0) begin n_fail++; $display("FAIL rst_ovf: got %0d expected 0", OutOverflow); end
        if (OutOvfFlag !== 1'b0)  begin n_fail++; $display("FAIL rst_flag: got %0b expected 0", OutOvfFlag); end
        if (OutSpecial !== 1'b0)  begin n_fail++; $display("FAIL rst_special: got %0b expected 0", OutSpecial); end
        if (OutSticky !== 1'b0)   begin n_fail++; $display("FAIL rst_sticky: got %0b expected 0", OutSticky); end
        if (OutOvfCount !== 4'd0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", OutOvfCount); end
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;
    endtask

    task automatic test_boundary();
        logic [5:0] ovf;
        logic spec, flag;
        clear_status();
        send(32'h42C80000, 6'd8);
        wait_out(ovf, spec, flag);
        n_cmp += 2;
        if (ovf !== 6'd0)  begin n_fail++; $display("FAIL b100_ovf: got %0d expected 0", ovf); end
        if (flag !== 1'b0) begin n_fail++; $display("FAIL b100_flag: got %0b expected 0", flag); end
        send(32'h43000000, 6'd8);
        wait_out(ovf, spec, flag);
        n_cmp += 2;
        if (ovf !== 6'd1)  begin n_fail++; $display("FAIL b128_ovf: got %0d expected 1", ovf); end
        if (flag !== 1'b1) begin n_fail++; $display("FAIL b128_flag: got %0b expected 1", flag); end
        drain();
        n_cmp += 2;
        if (OutSticky !== 1'b1)   begin n_fail++; $display("FAIL b128_sticky: got %0b expected 1", OutSticky); end
        if (OutOvfCount !== 4'd1) begin n_fail++; $display("FAIL b128_count: got %0d expected 1", OutOvfCount); end
    endtask

    task automatic test_clamp_specials();
        logic [5:0] ovf;
        logic spec, flag;
        send(32'h62800000, 6'd8);
        wait_out(ovf, spec, flag);
        n_cmp += 2;
        if (ovf !== 6'd63) begin n_fail++; $display("FAIL clamp_ovf: got %0d expected 63", ovf); end
        if (spec !== 1'b0) begin n_fail++; $display("FAIL clamp_spec: got %0b expected 0", spec); end
        send(32'h7F800000, 6'd8);
        wait_out(ovf, spec, flag);
        n_cmp += 3;
        if (ovf !== 6'd63) begin n_fail++; $display("FAIL inf_ovf: got %0d expected 63", ovf); end
        if (spec !== 1'b1) begin n_fail++; $display("FAIL inf_spec: got %0b expected 1", spec); end
        if (flag !== 1'b1) begin n_fail++; $display("FAIL inf_flag: got %0b expected 1", flag); end
        send(32'h00000001, 6'd8);
        wait_out(ovf, spec, flag);
        n_cmp += 2;
        if (ovf !== 6'd0)  begin n_fail++; $display("FAIL denorm_ovf: got %0d expected 0", ovf); end
        if (spec !== 1'b0) begin n_fail++; $display("FAIL denorm_spec: got %0b expected 0", spec); end
    endtask

    task automatic test_negative_avail();
        logic [5:0] ovf;
        logic spec, flag;
        send(32'h3F800000, 6'd20);
        wait_out(ovf, spec, flag);
        n_cmp++;
        if (ovf !== 6'd6) begin n_fail++; $display("FAIL neg_avail_ovf: got %0d expected 6", ovf); end
    endtask

    task automatic test_back_to_back();
        int x0;
        drain();
        clear_status();
        x0 = n_xfer;
        stall_seen = 1'b0;
        fork
            begin
                send(32'h43800000, 6'd8);
                send(32'h44000000, 6'd8);
                send(32'h44800000, 6'd8);
                send(32'h45000000, 6'd8);
            end
            begin
                InReady = 1'b0;
                repeat (4) @(posedge Clk);
                #1;
                InReady = 1'b1;
            end
        join
        drain();
        n_cmp += 3;
        if (stall_seen !== 1'b1)  begin n_fail++; $display("FAIL b2b_stall: got %0b expected 1", stall_seen); end
        if (n_xfer - x0 != 4)     begin n_fail++; $display("FAIL b2b_xfers: got %0d expected 4", n_xfer - x0); end
        if (OutOvfCount !== 4'd4) begin n_fail++; $display("FAIL b2b_count: got %0d expected 4", OutOvfCount); end
    endtask

    task automatic test_counter_limits();
        int x0;
        clear_status();
        for (int i = 0; i < 20; i++) send(32'h62800000 - 32'(i << 23), 6'd8);
        drain();
        n_cmp += 2;
        if (OutOvfCount !== 4'd15) begin n_fail++; $display("FAIL sat_count: got %0d expected 15", OutOvfCount); end
        if (OutSticky !== 1'b1)    begin n_fail++; $display("FAIL sat_sticky: got %0b expected 1", OutSticky); end
        x0 = n_xfer;
        send(32'h43000000, 6'd8);
        @(posedge Clk);
        #1;
        InClear = 1'b1;
        @(posedge Clk);
        #1;
        InClear = 1'b0;
        n_cmp += 3;
        if (n_xfer - x0 != 1)     begin n_fail++; $display("FAIL clr_xfer: got %0d expected 1", n_xfer - x0); end
        if (OutOvfCount !== 4'd0) begin n_fail++; $display("FAIL clr_count: got %0d expected 0", OutOvfCount); end
        if (OutSticky !== 1'b0)   begin n_fail++; $display("FAIL clr_sticky: got %0b expected 0", OutSticky); end
    endtask

    task automatic test_random();
        int x0;
        logic done;
        x0 = n_xfer;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) send(rand_float(), 6'($urandom_range(0, 63)));
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge Clk);
                    #1;
                    InReady = ($urandom_range(0, 3) != 0);
                end
                InReady = 1'b1;
            end
        join
        drain();
        n_cmp++;
        if (n_xfer - x0 != 40) begin n_fail++; $display("FAIL rand_xfers: got %0d expected 40", n_xfer - x0); end
    endtask

    task automatic test_async_reset();
        send(32'h43000000, 6'd8);
        drain();
        send(32'h43800000, 6'd8);
        send(32'h44000000, 6'd8);
        #1;
        Rst = 1'b1;
        #1;
        n_cmp += 5;
        if (OutValid !== 1'b0)    begin n_fail++; $display("FAIL arst_valid: got %0b expected 0", OutValid); end
        if (OutOverflow !== 6'd0) begin n_fail++; $display("FAIL arst_ovf: got %0d expected 0", OutOverflow); end
        if (OutOvfFlag !== 1'b0)  begin n_fail++; $display("FAIL arst_flag: got %0b expected 0", OutOvfFlag); end
        if (OutSticky !== 1'b0)   begin n_fail++; $display("FAIL arst_sticky: got %0b expected 0", OutSticky); end
        if (OutOvfCount !== 4'd0) begin n_fail++; $display("FAIL arst_count: got %0d expected 0", OutOvfCount); end
        #3;
        Rst = 1'b0;
        for (int t = 0; t < 5; t++) begin
            @(negedge Clk);
            n_cmp++;
            if (OutValid !== 1'b0) begin n_fail++; $display("FAIL arst_ghost: got OutValid=%0b expected 0", OutValid); end
        end
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Rst = 1'b1;
        InFloat = '0;
        InRadixPoint = '0;
        InValid = 1'b0;
        InReady = 1'b1;
        InClear = 1'b0;
        stall_seen = 1'b0;
        test_reset();
        test_boundary();
        test_clamp_specials();
        test_negative_avail();
        test_back_to_back();
        test_counter_limits();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
